// File: rtl/fir_filter_if.sv
// Sample, LUT-load and result signals of the DA FIR filter bundled into one interface.
// The overrun signal exists only when FIR_OVERRUN_FLAG_EN is defined.
interface fir_filter_if #(
    parameter int DW = 16,
    parameter int CW = 20,
    parameter int OW = 39
);
    logic signed [DW-1:0] din;
    logic                 valid_in;
    logic signed [CW-1:0] CIN;
    logic        [10:0]   CADDR;
    logic                 CLOAD;
    logic signed [OW-1:0] dout;
    logic                 valid_out;
`ifdef FIR_OVERRUN_FLAG_EN
    logic                 overrun;
`endif

    modport master (
        output din, valid_in, CIN, CADDR, CLOAD,
`ifdef FIR_OVERRUN_FLAG_EN
        input  overrun,
`endif
        input  dout, valid_out
    );

    modport slave (
        input  din, valid_in, CIN, CADDR, CLOAD,
`ifdef FIR_OVERRUN_FLAG_EN
        output overrun,
`endif
        output dout, valid_out
    );
endinterface

// File: rtl/fir_filter.sv
// 64-tap bit-serial distributed-arithmetic FIR: 8 groups x 8 taps, one input bit per cycle.
// Optional sticky overrun flag on dropped samples: define FIR_OVERRUN_FLAG_EN.
module fir_filter #(
    parameter int DW   = 16,
    parameter int CW   = 20,
    parameter int OW   = 39,
    parameter int TAPS = 64
) (
    input logic         clk,
    input logic         resetn,
    fir_filter_if.slave bus
);
    localparam int GROUPS = TAPS / 8;
    localparam int LUT_D  = GROUPS * 256;
    localparam int SW     = CW + 3;

    logic signed [CW-1:0] lut [0:LUT_D-1];
    logic signed [DW-1:0] x [0:TAPS-1];
    logic [7:0]           pat [0:GROUPS-1];
    logic signed [SW-1:0] sum_p0;
    logic signed [OW-1:0] acc_p1;
    logic signed [OW-1:0] dout_p2;
    logic                 vld_p2;
    logic                 busy;
    logic [3:0]           bit_idx;
    logic                 accept;

    function automatic logic signed [SW-1:0] sext_entry(input logic signed [CW-1:0] e);
        return {{(SW-CW){e[CW-1]}}, e};
    endfunction

    function automatic logic signed [OW-1:0] scale(input logic signed [SW-1:0] s,
                                                   input logic [3:0] sh);
        logic signed [OW-1:0] wide;
        wide = {{(OW-SW){s[SW-1]}}, s};
        return wide <<< sh;
    endfunction

    assign accept = bus.valid_in && !busy && !bus.CLOAD;

    // The table has no reset: its contents survive resetn.
    always_ff @(posedge clk) begin
        if (bus.CLOAD) lut[bus.CADDR] <= bus.CIN;
    end

    // Stage 0: gather bit b of every tap into per-group patterns and sum the LUT partials.
    always_comb begin
        sum_p0 = '0;
        for (int g = 0; g < GROUPS; g++) begin
            pat[g] = '0;
            for (int j = 0; j < 8; j++) pat[g][j] = x[8*g+j][bit_idx];
            sum_p0 = sum_p0 + sext_entry(lut[{g[2:0], pat[g]}]);
        end
    end

    // Stage 1/2: shift-accumulate, the sign bit is subtracted and lands in dout.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy    <= 1'b0;
            bit_idx <= '0;
            acc_p1  <= '0;
            dout_p2 <= '0;
            vld_p2  <= 1'b0;
            for (int t = 0; t < TAPS; t++) x[t] <= '0;
        end else begin
            vld_p2 <= 1'b0;
            if (accept) begin
                for (int t = TAPS-1; t > 0; t--) x[t] <= x[t-1];
                x[0]    <= bus.din;
                acc_p1  <= '0;
                bit_idx <= '0;
                busy    <= 1'b1;
            end else if (busy) begin
                if (bit_idx == 4'd15) begin
                    dout_p2 <= acc_p1 - scale(sum_p0, 4'd15);
                    vld_p2  <= 1'b1;
                    busy    <= 1'b0;
                end else begin
                    acc_p1  <= acc_p1 + scale(sum_p0, bit_idx);
                    bit_idx <= bit_idx + 4'd1;
                end
            end
        end
    end

    assign bus.dout      = dout_p2;
    assign bus.valid_out = vld_p2;

`ifdef FIR_OVERRUN_FLAG_EN
    logic overrun_r;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            overrun_r <= 1'b0;
        else if (bus.valid_in && (busy || bus.CLOAD))
            overrun_r <= 1'b1;
    end

    assign bus.overrun = overrun_r;
`endif
endmodule

// File: tb/tb_fir_filter.sv
// Self-checking bench for fir_filter: directed scenarios plus random taps/samples
// compared against a direct-form convolution model.
module tb_fir_filter;
    logic clk = 1'b0;
    logic resetn;
    int   nchecks = 0;
    int   nfail   = 0;

    longint h [0:63];
    longint hist [0:63];

    fir_filter_if bus ();

    fir_filter dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint lut_entry(input int a);
        longint s = 0;
        int g = a / 256;
        int p = a % 256;
        for (int j = 0; j < 8; j++)
            if (((p >> j) & 1) == 1) s += h[8*g+j];
        return s;
    endfunction

    function automatic longint model_out();
        longint s = 0;
        for (int t = 0; t < 64; t++) s += h[t] * hist[t];
        return s;
    endfunction

    task automatic model_push(input logic signed [15:0] v);
        for (int t = 63; t > 0; t--) hist[t] = hist[t-1];
        hist[0] = longint'(v);
    endtask

    task automatic model_clear();
        for (int t = 0; t < 64; t++) hist[t] = 0;
    endtask

    task automatic load_lut();
        longint e;
        for (int a = 0; a < 2048; a++) begin
            @(negedge clk);
            e = lut_entry(a);
            bus.CLOAD = 1'b1;
            bus.CADDR = 11'(a);
            bus.CIN   = e[19:0];
        end
        @(negedge clk);
        bus.CLOAD = 1'b0;
    endtask

    task automatic send(input string tag, input logic signed [15:0] v, input int gap);
        int lat = 0;
        @(negedge clk);
        bus.din = v;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.din = 16'sd0;
        model_push(v);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) begin
                lat = k;
                break;
            end
        end
        check({tag, "_latency"}, lat, 16);
        check({tag, "_dout"}, bus.dout, model_out());
        @(negedge clk);
        check({tag, "_pulse"}, bus.valid_out, 0);
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        longint e;
        int cnt;
        logic signed [15:0] v;

        resetn = 1'b0;
        bus.din = '0;
        bus.valid_in = 1'b0;
        bus.CIN = '0;
        bus.CADDR = '0;
        bus.CLOAD = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("reset_dout", bus.dout, 0);
        check("reset_valid", bus.valid_out, 0);
`ifdef FIR_OVERRUN_FLAG_EN
        check("reset_overrun", bus.overrun, 0);
`endif
        resetn = 1'b1;

        // Impulse response with h[t] = t+1.
        for (int t = 0; t < 64; t++) h[t] = t + 1;
        load_lut();
        send("imp0", 16'sd1, 3);
        for (int n = 1; n <= 64; n++) send($sformatf("imp%0d", n), 16'sd0, 3);
        check("imp_tail", bus.dout, 0);

        // Sign handling on a single tap.
        for (int t = 0; t < 64; t++) h[t] = 0;
        h[0] = 16383;
        load_lut();
        send("sign_neg", -16'sd32768, 2);
        check("sign_value", bus.dout, -64'sd536838144);
        send("sign_zero", 16'sd0, 2);

        // Largest magnitude result.
        for (int t = 0; t < 64; t++) h[t] = -16384;
        load_lut();
        for (int n = 0; n < 64; n++) send("maxmag", -16'sd32768, 0);
        check("maxmag_value", bus.dout, 64'sd34359738368);

        // Random taps and samples, starting from a cleared line.
        for (int t = 0; t < 64; t++) h[t] = longint'($urandom_range(0, 32767)) - 16384;
        load_lut();
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        model_clear();
        for (int n = 0; n < 50; n++) begin
            v = 16'(int'($urandom_range(0, 32767)) - 16384);
            send("rand", v, int'($urandom_range(0, 3)));
        end

        // Dropped samples: while busy, and alongside CLOAD.
`ifdef FIR_OVERRUN_FLAG_EN
        check("overrun_clear", bus.overrun, 0);
`endif
        @(negedge clk);
        v = 16'sd1234;
        bus.din = v;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        model_push(v);
        e = model_out();
        repeat (4) @(negedge clk);
        bus.din = -16'sd777;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) cnt++;
        end
        check("busy_drop_count", cnt, 1);
        check("busy_drop_dout", bus.dout, e);
        @(negedge clk);
        bus.CLOAD = 1'b1;
        bus.CADDR = 11'd0;
        bus.CIN = 20'sd0;
        bus.din = 16'sd999;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.CLOAD = 1'b0;
        bus.valid_in = 1'b0;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) cnt++;
        end
        check("cload_drop_count", cnt, 0);
        send("after_drop", 16'sd321, 2);
`ifdef FIR_OVERRUN_FLAG_EN
        check("overrun_set", bus.overrun, 1);
`endif

        // Reset in the middle of a computation.
        @(negedge clk);
        bus.din = 16'sd4321;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midreset_dout", bus.dout, 0);
        check("midreset_valid", bus.valid_out, 0);
`ifdef FIR_OVERRUN_FLAG_EN
        check("midreset_overrun", bus.overrun, 0);
`endif
        model_clear();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.valid_out === 1'b1) cnt++;
        end
        check("midreset_no_result", cnt, 0);
        send("post_reset_zero", 16'sd0, 2);
        check("post_reset_value", bus.dout, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end
endmodule
